sccb_ctrl: RTL and testbench

SCCB_CTRL -- requirements
Module: sccb_ctrl

---
 rtl/sccb_ctrl_pkg.sv | 25 ++
 rtl/sccb_ctrl_tick.sv | 28 ++
 rtl/sccb_ctrl.sv | 138 +++++++++++++
 tb/tb_sccb_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_ctrl_pkg.sv
// Shared SCCB write-controller definitions: FSM states, quarter counts per phase
// and the bit total of a 3-phase write.
package sccb_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_STOP,
        ST_BUF
    } state_t;

    localparam int Q_START   = 2;
    localparam int Q_BIT     = 4;
    localparam int Q_STOP    = 3;
    localparam int Q_BUF     = 4;
    localparam int BIT_TOTAL = 27;
    localparam int TOTAL_Q   = Q_START + Q_BIT * BIT_TOTAL + Q_STOP + Q_BUF;

    // Bits 8, 17 and 26 are the 9th (don't-care) bit of each byte.
    function automatic logic is_ack_slot(input logic [4:0] bitn);
        return (bitn == 5'd8) || (bitn == 5'd17) || (bitn == 5'd26);
    endfunction

endpackage

// File: rtl/sccb_ctrl_tick.sv
// Quarter-bit tick generator: a 16-bit down-counter reloaded with CLK_DIV-1,
// restartable so the first quarter of a transaction is always full length.
module sccb_tick #(
    parameter int CLK_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || cnt == 16'd0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end

    assign tick = (cnt == 16'd0);

endmodule

// File: rtl/sccb_ctrl.sv
// SCCB 3-phase write master: START, dev_id, sub_addr, wr_data, STOP, bus-free.
// All bus and handshake outputs are registered from the next-state values.
module sccb_ctrl
    import sccb_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] dev_id,
    input  logic [7:0] sub_addr,
    input  logic [7:0] wr_data,
    output logic       ack,
    output logic       busy,
    output logic       done,
    output logic       sccb_c,
    output logic       sccb_d,
    output logic       sccb_d_oe
);

    state_t      state, state_n;
    logic [1:0]  q, q_n;
    logic [4:0]  bitn, bitn_n;
    logic [23:0] sh, sh_n;
    logic        accept;
    logic        tick;

    assign accept = (state == ST_IDLE) && req;

    sccb_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .tick    (tick)
    );

    // Bus levels {c, d, oe} for a given state/quarter; d is held across a whole bit.
    function automatic logic [2:0] bus_drive(input state_t s, input logic [1:0] qi,
                                             input logic [4:0] b, input logic msb);
        logic c;
        c = (qi == 2'd1) || (qi == 2'd2);
        case (s)
            ST_START: return {qi == 2'd0, 1'b0, 1'b1};
            ST_BIT:   return is_ack_slot(b) ? {c, 2'b00} : {c, msb, 1'b1};
            ST_STOP:  return {qi != 2'd0, qi == 2'd2, 1'b1};
            default:  return 3'b111;
        endcase
    endfunction

    always_comb begin
        state_n = state;
        q_n     = q;
        bitn_n  = bitn;
        sh_n    = sh;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_n = ST_START;
                    q_n     = '0;
                    bitn_n  = '0;
                    sh_n    = {dev_id, sub_addr, wr_data};
                end
            end
            ST_START: begin
                if (tick) begin
                    if (q == 2'(Q_START - 1)) begin
                        state_n = ST_BIT;
                        q_n     = '0;
                    end else begin
                        q_n = q + 2'd1;
                    end
                end
            end
            ST_BIT: begin
                if (tick) begin
                    if (q == 2'(Q_BIT - 1)) begin
                        q_n    = '0;
                        bitn_n = bitn + 5'd1;
                        // The 9th bit carries no data, so the shifter pauses on it.
                        if (!is_ack_slot(bitn)) begin
                            sh_n = {sh[22:0], 1'b0};
                        end
                        if (bitn == 5'(BIT_TOTAL - 1)) begin
                            state_n = ST_STOP;
                        end
                    end else begin
                        q_n = q + 2'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (q == 2'(Q_STOP - 1)) begin
                        state_n = ST_BUF;
                        q_n     = '0;
                    end else begin
                        q_n = q + 2'd1;
                    end
                end
            end
            ST_BUF: begin
                if (tick) begin
                    if (q == 2'(Q_BUF - 1)) begin
                        state_n = ST_IDLE;
                        q_n     = '0;
                    end else begin
                        q_n = q + 2'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                         <= ST_IDLE;
            q                             <= '0;
            bitn                          <= '0;
            sh                            <= '0;
            ack                           <= 1'b0;
            busy                          <= 1'b0;
            done                          <= 1'b0;
            {sccb_c, sccb_d, sccb_d_oe}   <= 3'b111;
        end else begin
            state                         <= state_n;
            q                             <= q_n;
            bitn                          <= bitn_n;
            sh                            <= sh_n;
            ack                           <= accept;
            busy                          <= (state_n != ST_IDLE);
            done                          <= (state == ST_BUF) && (state_n == ST_IDLE);
            {sccb_c, sccb_d, sccb_d_oe}   <= bus_drive(state_n, q_n, bitn_n, sh_n[23]);
        end
    end

endmodule

// File: tb/tb_sccb_ctrl.sv
// Bench for sccb_ctrl: two instances (CLK_DIV 4 and 2) share stimulus and are
// checked every cycle against a cycle-index model, plus bus decoding and corner sequences.
module tb_sccb_ctrl;
    import sccb_ctrl_pkg::*;

    localparam int DIV_A = 4;
    localparam int DIV_B = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic [7:0] dev_id = 8'h00, sub_addr = 8'h00, wr_data = 8'h00;
    logic ack_a, busy_a, done_a, c_a, d_a, oe_a;
    logic ack_b, busy_b, done_b, c_b, d_b, oe_b;

    always #5 clk = ~clk;

    sccb_ctrl #(.CLK_DIV(DIV_A)) dut_a (
        .clk(clk), .rst(rst), .req(req), .dev_id(dev_id), .sub_addr(sub_addr),
        .wr_data(wr_data), .ack(ack_a), .busy(busy_a), .done(done_a),
        .sccb_c(c_a), .sccb_d(d_a), .sccb_d_oe(oe_a)
    );

    sccb_ctrl #(.CLK_DIV(DIV_B)) dut_b (
        .clk(clk), .rst(rst), .req(req), .dev_id(dev_id), .sub_addr(sub_addr),
        .wr_data(wr_data), .ack(ack_b), .busy(busy_b), .done(done_b),
        .sccb_c(c_b), .sccb_d(d_b), .sccb_d_oe(oe_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {c, d, oe} k cycles after the ack cycle, from the quarter timeline.
    function automatic logic [2:0] bus_exp(input int k, input int div, input logic [23:0] data);
        int qn, b, qq, pos;
        logic [23:0] t;
        logic c;
        qn = k / div;
        if (qn < Q_START) return {qn == 0, 1'b0, 1'b1};
        qn = qn - Q_START;
        if (qn < Q_BIT * BIT_TOTAL) begin
            b   = qn / Q_BIT;
            qq  = qn % Q_BIT;
            pos = b % 9;
            c   = (qq == 1) || (qq == 2);
            if (pos == 8) return {c, 2'b00};
            t = data << ((b / 9) * 8 + pos);
            return {c, t[23], 1'b1};
        end
        qn = qn - Q_BIT * BIT_TOTAL;
        if (qn < Q_STOP) return {qn != 0, qn == 2, 1'b1};
        return 3'b111;
    endfunction

    // Reference models: exp_* = {ack, busy, done, c, d, oe} for the upcoming cycle.
    bit act_a = 1'b0, act_b = 1'b0;
    int k_a = 0, k_b = 0;
    logic [23:0] dat_a = '0, dat_b = '0;
    logic [5:0] exp_a = 6'b000111, exp_b = 6'b000111;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            act_a = 1'b0; exp_a = 6'b000111;
        end else if (!act_a && req) begin
            act_a = 1'b1; k_a = 0; dat_a = {dev_id, sub_addr, wr_data};
            exp_a = {3'b110, bus_exp(0, DIV_A, dat_a)};
        end else if (act_a) begin
            k_a++;
            if (k_a == TOTAL_Q * DIV_A) begin
                act_a = 1'b0; exp_a = 6'b001111;
            end else begin
                exp_a = {3'b010, bus_exp(k_a, DIV_A, dat_a)};
            end
        end else begin
            exp_a = 6'b000111;
        end
        if (rst) begin
            act_b = 1'b0; exp_b = 6'b000111;
        end else if (!act_b && req) begin
            act_b = 1'b1; k_b = 0; dat_b = {dev_id, sub_addr, wr_data};
            exp_b = {3'b110, bus_exp(0, DIV_B, dat_b)};
        end else if (act_b) begin
            k_b++;
            if (k_b == TOTAL_Q * DIV_B) begin
                act_b = 1'b0; exp_b = 6'b001111;
            end else begin
                exp_b = {3'b010, bus_exp(k_b, DIV_B, dat_b)};
            end
        end else begin
            exp_b = 6'b000111;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("cycle_a", 32'({ack_a, busy_a, done_a, c_a, d_a, oe_a}), 32'(exp_a));
            check("cycle_b", 32'({ack_b, busy_b, done_b, c_b, d_b, oe_b}), 32'(exp_b));
        end
    end

    // Bus decoders: sample SIO_D on SIO_C rise, count released cycles and
    // data edges that occur while SIO_C stays high.
    logic [26:0] bits_a = '0, bits_b = '0;
    int nb_a = 0, nb_b = 0, oe0_a = 0, oe0_b = 0;
    int hf_a = 0, hr_a = 0, hf_b = 0, hr_b = 0;
    logic pc_a = 1'b1, pd_a = 1'b1, pc_b = 1'b1, pd_b = 1'b1;

    initial forever begin
        @(negedge clk);
        if (ack_a) begin nb_a = 0; oe0_a = 0; hf_a = 0; hr_a = 0; end
        if (busy_a) begin
            if (c_a && !pc_a && nb_a < BIT_TOTAL) begin bits_a = {bits_a[25:0], d_a}; nb_a++; end
            if (!oe_a) oe0_a++;
            if (c_a && pc_a && d_a != pd_a) begin if (d_a) hr_a++; else hf_a++; end
        end
        pc_a = c_a; pd_a = d_a;
        if (ack_b) begin nb_b = 0; oe0_b = 0; hf_b = 0; hr_b = 0; end
        if (busy_b) begin
            if (c_b && !pc_b && nb_b < BIT_TOTAL) begin bits_b = {bits_b[25:0], d_b}; nb_b++; end
            if (!oe_b) oe0_b++;
            if (c_b && pc_b && d_b != pd_b) begin if (d_b) hr_b++; else hf_b++; end
        end
        pc_b = c_b; pd_b = d_b;
    end

    typedef struct {
        logic [7:0] dev;
        logic [7:0] sub;
        logic [7:0] wr;
        int lat_a;
        int lat_b;
        int oe0_a;
        int oe0_b;
    } vec_t;

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy_a && !busy_b) break;
            @(negedge clk);
        end
        check("idle_reached", 32'({busy_a, busy_b}), 32'(0));
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_a) break;
        end
        check("ack_seen", 32'(ack_a), 32'(1));
    endtask

    task automatic wait_done_a(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_a) break;
        end
        check("done_seen", 32'(done_a), 32'(1));
    endtask

    task automatic run_vec(input vec_t v);
        int la, lb;
        wait_idle(1000);
        @(negedge clk);
        dev_id = v.dev; sub_addr = v.sub; wr_data = v.wr; req = 1'b1;
        wait_ack();
        check("ack_b_same_cycle", 32'(ack_b), 32'(1));
        req = 1'b0;
        la = -1; lb = -1;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (i == 1) begin dev_id = 8'hFF; sub_addr = 8'hFF; wr_data = 8'hFF; end
            if (done_b && lb < 0) lb = i + 1;
            if (done_a) begin la = i + 1; break; end
        end
        check("latency_a", 32'(la), 32'(v.lat_a));
        check("latency_b", 32'(lb), 32'(v.lat_b));
        check("bytes_a", 32'({bits_a[26:19], bits_a[17:10], bits_a[8:1]}), 32'({v.dev, v.sub, v.wr}));
        check("bytes_b", 32'({bits_b[26:19], bits_b[17:10], bits_b[8:1]}), 32'({v.dev, v.sub, v.wr}));
        check("bitcount_a", 32'(nb_a), 32'(BIT_TOTAL));
        check("oe_release_a", 32'(oe0_a), 32'(v.oe0_a));
        check("oe_release_b", 32'(oe0_b), 32'(v.oe0_b));
        check("start_stop_a", 32'({hf_a[7:0], hr_a[7:0]}), 32'(16'h0101));
        check("start_stop_b", 32'({hf_b[7:0], hr_b[7:0]}), 32'(16'h0101));
    endtask

    initial begin
        vec_t tbl[5];
        int n_extra, nd;
        bit got;
        tbl[0] = '{8'h42, 8'h12, 8'h80, 469, 235, 48, 24};
        tbl[1] = '{8'h42, 8'h12, 8'h00, 469, 235, 48, 24};
        tbl[2] = '{8'h42, 8'h12, 8'hFF, 469, 235, 48, 24};
        tbl[3] = '{8'h60, 8'hA5, 8'h5A, 469, 235, 48, 24};
        tbl[4] = '{8'h00, 8'h00, 8'h00, 469, 235, 48, 24};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_a", 32'({ack_a, busy_a, done_a, c_a, d_a, oe_a}), 32'(6'b000111));
        check("reset_b", 32'({ack_b, busy_b, done_b, c_b, d_b, oe_b}), 32'(6'b000111));
        rst = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Request held through a transaction with a second request waiting.
        wait_idle(1000);
        @(negedge clk);
        dev_id = 8'h42; sub_addr = 8'h12; wr_data = 8'h80; req = 1'b1;
        wait_ack();
        @(negedge clk);
        dev_id = 8'h21; sub_addr = 8'h34; wr_data = 8'h56;
        n_extra = 0; got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (done_a) begin got = 1'b1; break; end
            if (ack_a) n_extra++;
            @(negedge clk);
        end
        check("held_no_early_ack", 32'(n_extra), 32'(0));
        check("held_done", 32'(got), 32'(1));
        @(negedge clk);
        check("held_ack_after_done", 32'(ack_a), 32'(1));
        req = 1'b0;
        wait_done_a(600);
        check("held_second_bytes", 32'({bits_a[26:19], bits_a[17:10], bits_a[8:1]}), 32'(24'h213456));

        // Reset in the middle of the second byte.
        wait_idle(1000);
        @(negedge clk);
        dev_id = 8'h42; sub_addr = 8'h12; wr_data = 8'h80; req = 1'b1;
        wait_ack();
        req = 1'b0;
        repeat (199) @(negedge clk);
        check("abort_busy_before", 32'({busy_a, busy_b}), 32'(2'b11));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_idle_a", 32'({ack_a, busy_a, done_a, c_a, d_a, oe_a}), 32'(6'b000111));
        check("abort_idle_b", 32'({ack_b, busy_b, done_b, c_b, d_b, oe_b}), 32'(6'b000111));
        nd = 0;
        repeat (600) begin
            @(negedge clk);
            if (done_a || done_b) nd++;
        end
        check("abort_no_done", 32'(nd), 32'(0));

        // Request held while reset is released.
        @(negedge clk);
        rst = 1'b1; req = 1'b1;
        dev_id = 8'($urandom); sub_addr = 8'($urandom); wr_data = 8'($urandom);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ack_a", 32'(ack_a), 32'(1));
        check("rst_release_ack_b", 32'(ack_b), 32'(1));
        req = 1'b0;

        // Random transactions with input jitter and req held past ack.
        for (int n = 0; n < 6; n++) begin
            int hold;
            wait_idle(1000);
            repeat ($urandom_range(0, 15)) @(negedge clk);
            dev_id = 8'($urandom); sub_addr = 8'($urandom); wr_data = 8'($urandom);
            req = 1'b1;
            wait_ack();
            hold = $urandom_range(0, 4);
            for (int i = 0; i < 30; i++) begin
                req = (i < hold);
                dev_id = 8'($urandom); sub_addr = 8'($urandom); wr_data = 8'($urandom);
                @(negedge clk);
            end
            req = 1'b0;
        end

        wait_idle(1000);
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
